// File: rtl/pipe_pkg.sv
// Shared types and constants for the CPU pipeline stage registers.
package pipe_pkg;

  // Stage occupancy state; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int OCC_W    = 2;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 72;

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload register with load enable and asynchronous reset to RESET_VAL.
module pipe_skid_entry #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_r;

  // Payload storage; holds its value unless load is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= RESET_VAL;
    end else if (load) begin
      data_r <= d;
    end else begin
      data_r <= data_r;
    end
  end

  assign q = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and hold.
// Define PIPE_REG_SKID_EN for the two-entry skid variant with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             hold,
  output logic [OCC_W-1:0] occ
);

  pipe_state_e      state_r;
  pipe_state_e      state_nxt_s;
  logic             main_valid_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             main_load_s;
  logic [WIDTH-1:0] main_d_s;
  logic [WIDTH-1:0] main_q_s;
`ifdef PIPE_REG_SKID_EN
  logic             skid_valid_s;
  logic             skid_load_s;
  logic [WIDTH-1:0] skid_q_s;
`endif

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: flush wins over everything, including an accept in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) state_nxt_s = ST_ONE;
          else           state_nxt_s = ST_EMPTY;
        end
        ST_ONE: begin
`ifdef PIPE_REG_SKID_EN
          if (in_fire_s && !out_fire_s)      state_nxt_s = ST_TWO;
          else if (!in_fire_s && out_fire_s) state_nxt_s = ST_EMPTY;
          else                               state_nxt_s = ST_ONE;
`else
          if (!in_fire_s && out_fire_s) state_nxt_s = ST_EMPTY;
          else                          state_nxt_s = ST_ONE;
`endif
        end
        ST_TWO: begin
          if (out_fire_s) state_nxt_s = ST_ONE;
          else            state_nxt_s = ST_TWO;
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs and data-register load enables.
  always_comb begin
    main_valid_s = (state_r != ST_EMPTY);
`ifdef PIPE_REG_SKID_EN
    skid_valid_s = (state_r == ST_TWO);
    // Depends only on registered state, so out_ready never reaches in_ready.
    in_ready     = ~skid_valid_s & ~hold;
`else
    in_ready     = (~main_valid_s | out_ready) & ~hold;
`endif
    out_valid    = main_valid_s & ~hold;
    in_fire_s    = in_valid & in_ready;
    out_fire_s   = out_valid & out_ready;
    main_load_s  = ~flush & (((state_r == ST_EMPTY) & in_fire_s)
                           | ((state_r == ST_ONE) & in_fire_s & out_fire_s)
                           | ((state_r == ST_TWO) & out_fire_s));
`ifdef PIPE_REG_SKID_EN
    skid_load_s  = ~flush & (state_r == ST_ONE) & in_fire_s & ~out_fire_s;
    if (state_r == ST_TWO) begin
      main_d_s = skid_q_s;
    end else begin
      main_d_s = in_data;
    end
`else
    main_d_s     = in_data;
`endif
  end

  pipe_skid_entry #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

`ifdef PIPE_REG_SKID_EN
  pipe_skid_entry #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load_s),
    .d     (in_data),
    .q     (skid_q_s)
  );
`endif

  assign out_data = main_q_s;
  assign occ      = state_r;

endmodule
